// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the RV32 core, feeding the register-file write port.
//   Accepts retiring instructions from MEM over in_valid/in_ready. ALU results are written
//   the cycle after acceptance. Loads wait for the data-bus response, which is then aligned,
//   extended and written. The stage also handles flush, response timeout and sticky error flags.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        handshake from MEM (in_ready is combinational from state)
//   in_rd, in_rd_wen           destination register and its write enable
//   in_is_load, in_funct3,
//   in_addr_lo                 load descriptor
//   in_alu_result              writeback value for non-loads
//   bus_rsp_valid/_data        data-bus read response
//   flush                      abandon the pending load
//   REGS_wen/_wraddr/_wrdata   register-file write port (registered, one-cycle pulse)
//   err_*                      sticky error flags
module wb_stage #(
  parameter int unsigned RSP_TIMEOUT = 64,
  parameter int unsigned TO_W        = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_alu_result,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_data,
  input  logic        flush,
  output logic        REGS_wen,
  output logic [4:0]  REGS_wraddr,
  output logic [31:0] REGS_wrdata,
  output logic        err_misalign,
  output logic        err_funct3,
  output logic        err_timeout,
  output logic        err_unexp_rsp
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic            rd_wen_q, rd_wen_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lo_q, lo_d;

  logic            wen_d;
  logic [4:0]      wraddr_d;
  logic [31:0]     wrdata_d;
  logic            err_mis_d, err_f3_d, err_to_d, err_unexp_d;

  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     ext_data;
  logic            bad_f3;
  logic            misalign;
  logic            timeout;

  assign in_ready = (state_q == IDLE);
  assign timeout  = (cnt_q == TO_W'(RSP_TIMEOUT - 1));

  // Align and extend the response according to the captured load descriptor.
  always_comb begin
    byte_sel = bus_rsp_data[{lo_q, 3'b000} +: 8];
    half_sel = bus_rsp_data[{lo_q[1], 4'b0000} +: 16];
    ext_data = bus_rsp_data;
    case (f3_q)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext_data = {24'd0, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext_data = {16'd0, half_sel};
      default: ext_data = bus_rsp_data;
    endcase
    bad_f3   = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);
    misalign = ((f3_q[1:0] == 2'b01) && lo_q[0]) ||
               ((f3_q == 3'b010) && (lo_q != 2'b00));
  end

  // Next-state, capture, write-port and error-flag logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    rd_wen_d    = rd_wen_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    wen_d       = 1'b0;
    wraddr_d    = REGS_wraddr;
    wrdata_d    = REGS_wrdata;
    err_mis_d   = err_misalign;
    err_f3_d    = err_funct3;
    err_to_d    = err_timeout;
    err_unexp_d = err_unexp_rsp;

    case (state_q)
      IDLE: begin
        // A stray response is flagged; it never satisfies a load accepted this cycle.
        if (bus_rsp_valid) err_unexp_d = 1'b1;
        if (in_valid) begin
          if (in_is_load) begin
            rd_d     = in_rd;
            rd_wen_d = in_rd_wen;
            f3_d     = in_funct3;
            lo_d     = in_addr_lo;
            cnt_d    = '0;
            state_d  = WAIT_RSP;
          end else if (in_rd_wen && (in_rd != 5'd0)) begin
            wen_d    = 1'b1;
            wraddr_d = in_rd;
            wrdata_d = in_alu_result;
          end
        end
      end

      WAIT_RSP: begin
        cnt_d = cnt_q + TO_W'(1);
        if (bus_rsp_valid) begin
          state_d = IDLE;
          // A flush in the same cycle discards the response.
          if (!flush) begin
            if (bad_f3) begin
              err_f3_d = 1'b1;
            end else if (misalign) begin
              err_mis_d = 1'b1;
            end else if (rd_wen_q && (rd_q != 5'd0)) begin
              wen_d    = 1'b1;
              wraddr_d = rd_q;
              wrdata_d = ext_data;
            end
          end
        end else if (timeout) begin
          err_to_d = 1'b1;
          state_d  = IDLE;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // Counter keeps running so WAIT_RSP + DRAIN share one timeout budget.
        cnt_d = cnt_q + TO_W'(1);
        if (bus_rsp_valid) begin
          state_d = IDLE;
        end else if (timeout) begin
          err_to_d = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rd_q          <= 5'd0;
      rd_wen_q      <= 1'b0;
      f3_q          <= 3'd0;
      lo_q          <= 2'd0;
      REGS_wen      <= 1'b0;
      REGS_wraddr   <= 5'd0;
      REGS_wrdata   <= 32'd0;
      err_misalign  <= 1'b0;
      err_funct3    <= 1'b0;
      err_timeout   <= 1'b0;
      err_unexp_rsp <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_q          <= rd_d;
      rd_wen_q      <= rd_wen_d;
      f3_q          <= f3_d;
      lo_q          <= lo_d;
      REGS_wen      <= wen_d;
      REGS_wraddr   <= wraddr_d;
      REGS_wrdata   <= wrdata_d;
      err_misalign  <= err_mis_d;
      err_funct3    <= err_f3_d;
      err_timeout   <= err_to_d;
      err_unexp_rsp <= err_unexp_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed bench for wb_stage. Expected register writes are queued when the
// stimulus is driven and popped whenever the DUT pulses REGS_wen; outputs are sampled on
// the falling clock edge, inputs are changed right after sampling.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_data;
  logic        flush;
  logic        REGS_wen;
  logic [4:0]  REGS_wraddr;
  logic [31:0] REGS_wrdata;
  logic        err_misalign;
  logic        err_funct3;
  logic        err_timeout;
  logic        err_unexp_rsp;

  int          n_vec;
  int          n_err;
  logic [36:0] exp_q[$];

  wb_stage #(.RSP_TIMEOUT(64), .TO_W(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_rd_wen     (in_rd_wen),
    .in_is_load    (in_is_load),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .in_alu_result (in_alu_result),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_data  (bus_rsp_data),
    .flush         (flush),
    .REGS_wen      (REGS_wen),
    .REGS_wraddr   (REGS_wraddr),
    .REGS_wrdata   (REGS_wrdata),
    .err_misalign  (err_misalign),
    .err_funct3    (err_funct3),
    .err_timeout   (err_timeout),
    .err_unexp_rsp (err_unexp_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Every write pulse must match the oldest outstanding expectation.
  task automatic monitor();
    logic [36:0] e;
    if (REGS_wen !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 32'(REGS_wen), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(REGS_wraddr), 32'(e[36:32]));
        check("wr_data", REGS_wrdata, e[31:0]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic drive_nl(input logic [4:0] rd, input logic wen, input logic [31:0] res);
    in_valid      = 1'b1;
    in_is_load    = 1'b0;
    in_rd         = rd;
    in_rd_wen     = wen;
    in_alu_result = res;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd);
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_rd      = rd;
    in_rd_wen  = 1'b1;
    in_funct3  = f3;
    in_addr_lo = lo;
  endtask

  // Accept a load, hold the response back wait_cyc cycles, then deliver it.
  task automatic load_rsp(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                          input logic [4:0] rd, input logic [31:0] data, input int wait_cyc,
                          input bit wr, input logic [31:0] exp_data);
    drive_load(f3, lo, rd);
    check({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < wait_cyc; i++) begin
      check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
      tick();
    end
    check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = data;
    if (wr) exp_q.push_back({rd, exp_data});
    tick();
    bus_rsp_valid = 1'b0;
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_rd         = 5'd0;
    in_rd_wen     = 1'b0;
    in_is_load    = 1'b0;
    in_funct3     = 3'd0;
    in_addr_lo    = 2'd0;
    in_alu_result = 32'd0;
    bus_rsp_valid = 1'b0;
    bus_rsp_data  = 32'd0;
    flush         = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_wen", 32'(REGS_wen), 32'd0);
    check("rst_wraddr", 32'(REGS_wraddr), 32'd0);
    check("rst_wrdata", REGS_wrdata, 32'd0);
    check("rst_errs", 32'({err_misalign, err_funct3, err_timeout, err_unexp_rsp}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back non-loads, each written exactly one cycle after acceptance.
    drive_nl(5'd1, 1'b1, 32'h11); exp_q.push_back({5'd1, 32'h11}); tick();
    check("b2b_wen1", 32'(REGS_wen), 32'd1);
    drive_nl(5'd2, 1'b1, 32'h22); exp_q.push_back({5'd2, 32'h22}); tick();
    check("b2b_wen2", 32'(REGS_wen), 32'd1);
    drive_nl(5'd3, 1'b1, 32'h33); exp_q.push_back({5'd3, 32'h33}); tick();
    check("b2b_wen3", 32'(REGS_wen), 32'd1);
    drive_nl(5'd0, 1'b1, 32'h44); tick();
    check("rd0_nowen", 32'(REGS_wen), 32'd0);
    drive_nl(5'd5, 1'b0, 32'h55); tick();
    check("rdwen0_nowen", 32'(REGS_wen), 32'd0);
    in_valid = 1'b0;
    tick();
    check("hold_addr", 32'(REGS_wraddr), 32'd3);
    check("hold_data", REGS_wrdata, 32'h33);
    check("b2b_pending", 32'(exp_q.size()), 32'd0);

    // Load extension cases.
    load_rsp("lb3",  3'b000, 2'd3, 5'd7, 32'h80FF_1234, 5, 1'b1, 32'hFFFF_FF80);
    load_rsp("lbu3", 3'b100, 2'd3, 5'd8, 32'h80FF_1234, 5, 1'b1, 32'h0000_0080);
    load_rsp("lhu2", 3'b101, 2'd2, 5'd9, 32'h80FF_1234, 2, 1'b1, 32'h0000_80FF);
    load_rsp("lh2",  3'b001, 2'd2, 5'd10, 32'h80FF_1234, 0, 1'b1, 32'hFFFF_80FF);
    load_rsp("lh0",  3'b001, 2'd0, 5'd11, 32'h80FF_1234, 1, 1'b1, 32'h0000_1234);
    load_rsp("lb1",  3'b000, 2'd1, 5'd12, 32'h80FF_1234, 3, 1'b1, 32'h0000_0012);
    load_rsp("lw0",  3'b010, 2'd0, 5'd13, 32'h1234_5678, 1, 1'b1, 32'h1234_5678);
    load_rsp("lw_rd0", 3'b010, 2'd0, 5'd0, 32'hCAFE_F00D, 1, 1'b0, 32'd0);
    check("no_err_yet", 32'({err_misalign, err_funct3, err_timeout, err_unexp_rsp}), 32'd0);

    // Misaligned and illegal-funct3 loads: wait for the response, no write, flag set.
    load_rsp("lh1_mis", 3'b001, 2'd1, 5'd7, 32'h1234_5678, 2, 1'b0, 32'd0);
    check("misalign_flag", 32'(err_misalign), 32'd1);
    check("funct3_clear", 32'(err_funct3), 32'd0);
    load_rsp("f3_011", 3'b011, 2'd0, 5'd7, 32'h1234_5678, 1, 1'b0, 32'd0);
    check("funct3_flag", 32'(err_funct3), 32'd1);

    // Flush two cycles after accept; response drained three cycles later.
    drive_load(3'b010, 2'd0, 5'd14); tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1; tick();
    flush = 1'b0;
    check("drain_ready0", 32'(in_ready), 32'd0);
    flush = 1'b1; tick();
    flush = 1'b0;
    check("drain_ignores_flush", 32'(in_ready), 32'd0);
    tick();
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'hDEAD_BEEF;
    tick();
    bus_rsp_valid = 1'b0;
    check("drain_done_ready", 32'(in_ready), 32'd1);
    check("drain_no_unexp", 32'(err_unexp_rsp), 32'd0);

    // Flush and response in the same cycle.
    drive_load(3'b010, 2'd0, 5'd15); tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_data = 32'h0BAD_0BAD;
    tick();
    flush = 1'b0; bus_rsp_valid = 1'b0;
    check("flushrsp_ready", 32'(in_ready), 32'd1);
    check("flushrsp_no_unexp", 32'(err_unexp_rsp), 32'd0);
    check("flush_pending", 32'(exp_q.size()), 32'd0);

    // Timeout: 64 cycles in WAIT_RSP, then abort.
    check("to_clear", 32'(err_timeout), 32'd0);
    drive_load(3'b010, 2'd0, 5'd16); tick();
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check("to_cycles", 32'(n), 32'd64);
    check("to_flag", 32'(err_timeout), 32'd1);
    check("to_ready", 32'(in_ready), 32'd1);

    // Stray response while idle.
    check("unexp_clear", 32'(err_unexp_rsp), 32'd0);
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'h5555_AAAA;
    tick();
    bus_rsp_valid = 1'b0;
    check("unexp_flag", 32'(err_unexp_rsp), 32'd1);

    // Stray response in the accept cycle must not complete the new load.
    drive_load(3'b010, 2'd0, 5'd17);
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'h1111_1111;
    tick();
    in_valid = 1'b0; bus_rsp_valid = 1'b0;
    check("stray_not_consumed", 32'(in_ready), 32'd0);
    tick();
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'h2222_2222;
    exp_q.push_back({5'd17, 32'h2222_2222});
    tick();
    bus_rsp_valid = 1'b0;
    check("stray_load_pending", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of WAIT_RSP.
    drive_load(3'b000, 2'd0, 5'd18); tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_wen", 32'(REGS_wen), 32'd0);
    check("arst_wraddr", 32'(REGS_wraddr), 32'd0);
    check("arst_errs", 32'({err_misalign, err_funct3, err_timeout, err_unexp_rsp}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'h7777_7777;
    tick();
    bus_rsp_valid = 1'b0;
    check("post_rst_errs", 32'({err_misalign, err_funct3, err_timeout, err_unexp_rsp}), 32'd1);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    tick();
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
